hex_bcd_driver: RTL and testbench

Register-and-format stage directly upstream of the seven-segment output mapping. It accepts a 32-bit value written by the LSU's output-peripheral decode and converts it either to eight hex digits or to eight decimal digits. Decimal conversion is iterative double-dabble. The block drives the eight active-low 7-bit digit buses `o_io_hex0..o_io_hex7` that the display stage consumes. Outputs change atomically, only at the end of a conversion.

---
 rtl/hex_bcd_driver.sv | 198 +++++++++++++++++++
 tb/tb_hex_bcd_driver.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/hex_bcd_driver.sv
// hex_bcd_driver: latches a 32-bit store from the LSU and formats it as eight
// seven-segment digits. The format is either hex or unsigned decimal; decimal
// uses iterative double-dabble. All eight digit registers update together in
// COMMIT. A one-entry, last-write-wins pending slot absorbs stores that arrive
// while a conversion is running.
// Optional feature macro: HEX_BLANK_EN. When it is defined, leading zero
// digits in decimal mode are blanked.
module hex_bcd_driver #(
    parameter int unsigned SHIFT_CYC = 32
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_wr_en,
    input  logic [31:0] i_wr_data,
    input  logic        i_mode,
    output logic        o_busy,
    output logic [6:0]  o_io_hex0,
    output logic [6:0]  o_io_hex1,
    output logic [6:0]  o_io_hex2,
    output logic [6:0]  o_io_hex3,
    output logic [6:0]  o_io_hex4,
    output logic [6:0]  o_io_hex5,
    output logic [6:0]  o_io_hex6,
    output logic [6:0]  o_io_hex7
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DIGITS = 8;
    localparam int unsigned CNT_W  = $clog2(SHIFT_CYC);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SHIFT_CYC - 1);
    localparam logic [DATA_W-1:0] DEC_MAX   = 32'd99_999_999;
    localparam logic [6:0]        SEG_BLANK = 7'h7F;
    localparam logic [6:0]        SEG_DASH  = 7'h3F;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        SHIFT  = 2'd2,
        COMMIT = 2'd3
    } state_t;

    state_t             state;
    logic [DATA_W-1:0]  data_q;
    logic               mode_q;
    logic [DATA_W-1:0]  pend_data;
    logic               pend_mode;
    logic               pend_valid;
    logic [DATA_W-1:0]  shreg;
    logic [DATA_W-1:0]  bcd;
    logic [DATA_W-1:0]  bcd_adj;
    logic [CNT_W-1:0]   cnt;
    logic [6:0]         disp       [DIGITS];
    logic [6:0]         commit_seg [DIGITS];
    logic [3:0]         digit;
    logic               dec_ovf;
`ifdef HEX_BLANK_EN
    logic               lead;
`endif

    // Active-low segment pattern for one nibble (bit0 = a ... bit6 = g).
    function automatic logic [6:0] seg_encode(input logic [3:0] v);
        case (v)
            4'h0:    seg_encode = 7'h40;
            4'h1:    seg_encode = 7'h79;
            4'h2:    seg_encode = 7'h24;
            4'h3:    seg_encode = 7'h30;
            4'h4:    seg_encode = 7'h19;
            4'h5:    seg_encode = 7'h12;
            4'h6:    seg_encode = 7'h02;
            4'h7:    seg_encode = 7'h78;
            4'h8:    seg_encode = 7'h00;
            4'h9:    seg_encode = 7'h10;
            4'hA:    seg_encode = 7'h08;
            4'hB:    seg_encode = 7'h03;
            4'hC:    seg_encode = 7'h46;
            4'hD:    seg_encode = 7'h21;
            4'hE:    seg_encode = 7'h06;
            default: seg_encode = 7'h0E;
        endcase
    endfunction

    assign dec_ovf = (data_q > DEC_MAX);
    assign o_busy  = (state != IDLE) || pend_valid;

    assign o_io_hex0 = disp[0];
    assign o_io_hex1 = disp[1];
    assign o_io_hex2 = disp[2];
    assign o_io_hex3 = disp[3];
    assign o_io_hex4 = disp[4];
    assign o_io_hex5 = disp[5];
    assign o_io_hex6 = disp[6];
    assign o_io_hex7 = disp[7];

    // Double-dabble correction: add 3 to every BCD nibble that is >= 5 before it shifts.
    always_comb begin
        bcd_adj = bcd;
        for (int k = 0; k < 8; k++) begin
            if (bcd[4*k +: 4] >= 4'd5) begin
                bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
            end
        end
    end

    // Digit patterns loaded in COMMIT: hex nibbles, decimal BCD, or dashes on decimal overflow.
    always_comb begin
        digit = 4'h0;
`ifdef HEX_BLANK_EN
        lead  = 1'b1;
`endif
        for (int k = 7; k >= 0; k--) begin
            digit = bcd[4*k +: 4];
            if (!mode_q) begin
                commit_seg[k] = seg_encode(data_q[4*k +: 4]);
            end else if (dec_ovf) begin
                commit_seg[k] = SEG_DASH;
            end else begin
`ifdef HEX_BLANK_EN
                // hex0 always shows a digit, so the value zero still displays as "0".
                if (lead && (digit == 4'h0) && (k != 0)) begin
                    commit_seg[k] = SEG_BLANK;
                end else begin
                    commit_seg[k] = seg_encode(digit);
                    lead          = 1'b0;
                end
`else
                commit_seg[k] = seg_encode(digit);
`endif
            end
        end
    end

    // Conversion FSM, pending slot and the committed digit registers.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state      <= IDLE;
            data_q     <= '0;
            mode_q     <= 1'b0;
            pend_data  <= '0;
            pend_mode  <= 1'b0;
            pend_valid <= 1'b0;
            shreg      <= '0;
            bcd        <= '0;
            cnt        <= '0;
            for (int k = 0; k < 8; k++) begin
                disp[k] <= SEG_BLANK;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (pend_valid) begin
                        data_q <= pend_data;
                        mode_q <= pend_mode;
                        state  <= LOAD;
                        // A store landing in the consume cycle becomes the next pending entry.
                        if (i_wr_en) begin
                            pend_data <= i_wr_data;
                            pend_mode <= i_mode;
                        end else begin
                            pend_valid <= 1'b0;
                        end
                    end else if (i_wr_en) begin
                        data_q <= i_wr_data;
                        mode_q <= i_mode;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    bcd   <= '0;
                    shreg <= data_q;
                    cnt   <= '0;
                    state <= mode_q ? SHIFT : COMMIT;
                end
                SHIFT: begin
                    {bcd, shreg} <= {bcd_adj[DATA_W-2:0], shreg, 1'b0};
                    cnt          <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    for (int k = 0; k < 8; k++) begin
                        disp[k] <= commit_seg[k];
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Stores that arrive mid-conversion overwrite the pending slot.
            if ((state != IDLE) && i_wr_en) begin
                pend_valid <= 1'b1;
                pend_data  <= i_wr_data;
                pend_mode  <= i_mode;
            end
        end
    end

endmodule

// File: tb/tb_hex_bcd_driver.sv
// Directed, table-driven bench for hex_bcd_driver plus hand-written sequences
// for reset-abort and back-to-back pending behaviour.
module tb_hex_bcd_driver;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        mode;
    logic        busy;
    logic [6:0]  h0, h1, h2, h3, h4, h5, h6, h7;

    int vecs_n;
    int errs;

    hex_bcd_driver dut (
        .i_clk     (clk),
        .i_reset   (rst),
        .i_wr_en   (wr_en),
        .i_wr_data (wr_data),
        .i_mode    (mode),
        .o_busy    (busy),
        .o_io_hex0 (h0),
        .o_io_hex1 (h1),
        .o_io_hex2 (h2),
        .o_io_hex3 (h3),
        .o_io_hex4 (h4),
        .o_io_hex5 (h5),
        .o_io_hex6 (h6),
        .o_io_hex7 (h7)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        string       name;
        logic        mode;
        logic [31:0] data;
        logic [55:0] exp;
        int          lat;
    } vec_t;

    function automatic logic [55:0] p8(input logic [6:0] d7, input logic [6:0] d6,
                                       input logic [6:0] d5, input logic [6:0] d4,
                                       input logic [6:0] d3, input logic [6:0] d2,
                                       input logic [6:0] d1, input logic [6:0] d0);
        p8 = {d7, d6, d5, d4, d3, d2, d1, d0};
    endfunction

    function automatic logic [55:0] disp();
        disp = {h7, h6, h5, h4, h3, h2, h1, h0};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        vecs_n++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t vt[12];

    initial begin
        logic [55:0] prev;
        logic [55:0] all7f;
        logic [55:0] exp5;
        logic [55:0] exp1;
        logic [55:0] exp2;
        int          cyc;
        logic        hold_ok;
        logic        gap;
        logic        saw1;

        vecs_n  = 0;
        errs    = 0;
        all7f   = p8(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);

        vt[0]  = '{"hex_deadbeef", 1'b0, 32'hDEADBEEF,
                   p8(7'h21, 7'h06, 7'h08, 7'h21, 7'h03, 7'h06, 7'h06, 7'h0E), 2};
        vt[1]  = '{"hex_01234567", 1'b0, 32'h01234567,
                   p8(7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78), 2};
        vt[2]  = '{"hex_89abcdef", 1'b0, 32'h89ABCDEF,
                   p8(7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E), 2};
        vt[3]  = '{"dec_12345678", 1'b1, 32'd12345678,
                   p8(7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00), 34};
        vt[4]  = '{"dec_overflow_1e8", 1'b1, 32'd100000000,
                   p8(7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F), 34};
        vt[5]  = '{"dec_max_99999999", 1'b1, 32'd99999999,
                   p8(7'h10, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10), 34};
`ifdef HEX_BLANK_EN
        vt[6]  = '{"dec_42", 1'b1, 32'd42,
                   p8(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24), 34};
        vt[7]  = '{"dec_0", 1'b1, 32'd0,
                   p8(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40), 34};
        vt[8]  = '{"dec_10203", 1'b1, 32'd10203,
                   p8(7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h40, 7'h24, 7'h40, 7'h30), 34};
`else
        vt[6]  = '{"dec_42", 1'b1, 32'd42,
                   p8(7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h19, 7'h24), 34};
        vt[7]  = '{"dec_0", 1'b1, 32'd0,
                   p8(7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40), 34};
        vt[8]  = '{"dec_10203", 1'b1, 32'd10203,
                   p8(7'h40, 7'h40, 7'h40, 7'h79, 7'h40, 7'h24, 7'h40, 7'h30), 34};
`endif
        vt[9]  = '{"dec_overflow_ffffffff", 1'b1, 32'hFFFFFFFF,
                   p8(7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F), 34};
        vt[10] = '{"hex_zero", 1'b0, 32'h0,
                   p8(7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40), 2};
        vt[11] = '{"dec_87654321", 1'b1, 32'd87654321,
                   p8(7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79), 34};

        // Reset held low for two edges.
        rst     = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        mode    = 1'b0;
        step();
        step();
        chk("reset_display", 64'(disp()), 64'(all7f));
        chk("reset_busy", 64'(busy), 64'd0);
        rst = 1'b1;
        step();

        // Table vectors: latency, atomic hold while busy, final display, idle busy.
        for (int v = 0; v < 12; v++) begin
            prev    = disp();
            wr_en   = 1'b1;
            wr_data = vt[v].data;
            mode    = vt[v].mode;
            step();
            wr_en   = 1'b0;
            cyc     = 0;
            hold_ok = 1'b1;
            while (busy && cyc < 100) begin
                if (disp() !== prev) hold_ok = 1'b0;
                cyc++;
                step();
            end
            chk({vt[v].name, "_latency"}, 64'(cyc), 64'(vt[v].lat));
            chk({vt[v].name, "_hold"}, 64'(hold_ok), 64'd1);
            chk({vt[v].name, "_display"}, 64'(disp()), 64'(vt[v].exp));
            repeat (3) step();
            chk({vt[v].name, "_persist"}, 64'(disp()), 64'(vt[v].exp));
        end

        // Reset asserted mid-SHIFT aborts without committing partial data.
        wr_en   = 1'b1;
        wr_data = 32'd12345678;
        mode    = 1'b1;
        step();
        wr_en = 1'b0;
        repeat (10) step();
        rst = 1'b0;
        step();
        chk("midshift_reset_display", 64'(disp()), 64'(all7f));
        chk("midshift_reset_busy", 64'(busy), 64'd0);
        rst = 1'b1;
        repeat (40) step();
        chk("midshift_no_commit", 64'(disp()), 64'(all7f));
        chk("midshift_idle_busy", 64'(busy), 64'd0);

        // Decimal 5 at N, hex 1 at N+3, hex 2 at N+5: only 5 then 2 are shown.
`ifdef HEX_BLANK_EN
        exp5 = p8(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h12);
`else
        exp5 = p8(7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h12);
`endif
        exp1 = p8(7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h79);
        exp2 = p8(7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h24);
        gap  = 1'b0;
        saw1 = 1'b0;
        for (int i = 0; i <= 38; i++) begin
            wr_en   = (i == 0) || (i == 3) || (i == 5);
            mode    = (i == 0);
            wr_data = (i == 0) ? 32'd5 : ((i == 3) ? 32'h1 : 32'h2);
            step();
            wr_en = 1'b0;
            if (!busy && i < 37) gap = 1'b1;
            if (disp() === exp1) saw1 = 1'b1;
            if (i == 33) chk("b2b_before_commit", 64'(disp()), 64'(all7f));
            if (i == 34) chk("b2b_dec5_commit", 64'(disp()), 64'(exp5));
            if (i == 36) chk("b2b_hold_before_pending", 64'(disp()), 64'(exp5));
            if (i == 37) begin
                chk("b2b_pending_commit", 64'(disp()), 64'(exp2));
                chk("b2b_busy_after", 64'(busy), 64'd0);
            end
        end
        chk("b2b_busy_continuous", 64'(gap), 64'd0);
        chk("b2b_hex1_never_shown", 64'(saw1), 64'd0);
        chk("b2b_final_hold", 64'(disp()), 64'(exp2));

        $display("== %0d vectors applied, %0d miscompares ==", vecs_n, errs);
        $finish;
    end

endmodule
